// File: rtl/falcon_pkg.sv
// Shared fetch-stage types and constants: PC/instruction widths, reset vector,
// and the {pc, instr} record carried through the fetch buffer.
package falcon_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [PC_W-1:0] PC_STEP          = 16'd4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Byte addresses are forced onto a word boundary; the low two bits are dropped.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry fetch buffer. Slot 0 is always the head, so the head fields come
// straight from flops and never from a read-pointer mux.
module ifetch_fifo
  import falcon_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  fetch_entry_t slot1;
  logic         valid1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the data slots are reset as well as the valid bits, so the
      // instruction and pc seen by decode read as zero while in reset.
      head       <= '0;
      slot1      <= '0;
      head_valid <= 1'b0;
      valid1     <= 1'b0;
    end else if (flush) begin
      head_valid <= 1'b0;
      valid1     <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!head_valid) begin
            head       <= push_data;
            head_valid <= 1'b1;
          end else begin
            slot1  <= push_data;
            valid1 <= 1'b1;
          end
        end
        2'b01: begin
          head       <= slot1;
          head_valid <= valid1;
          valid1     <= 1'b0;
        end
        2'b11: begin
          // Simultaneous push and pop keeps the count unchanged.
          if (valid1) begin
            head  <= slot1;
            slot1 <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = 2'(head_valid) + 2'(valid1);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues word addresses to a 1-cycle-latency memory, buffers
// returned words in a 2-entry FIFO and handles redirects from execute.
module instruction_fetch
  import falcon_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clock,
  input  logic               resetn,
  output logic [15:2]        instr_address,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc
);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] pc_inflight;
  logic            inflight;
  logic [1:0]      fifo_count;
  logic [1:0]      occupancy;
  logic            transfer;
  logic            issue;
  logic            push;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  assign instr_address = fetch_pc[15:2];
  assign transfer      = if_valid && if_ready;

  // Occupancy counts the in-flight read as already owning a FIFO slot, so a
  // response always has somewhere to land.
  assign occupancy = fifo_count + 2'(inflight);
  assign issue     = !jump && ((occupancy < 2'd2) || (occupancy == 2'd2 && transfer));

  // A redirect discards the response of the old stream.
  assign push      = inflight && !jump;
  assign push_data = '{pc: pc_inflight, instr: instr_data};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fetch_pc    <= word_align(RESET_PC);
      pc_inflight <= '0;
      inflight    <= 1'b0;
    end else if (jump) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      fetch_pc <= word_align(jump_target);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_inflight <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_STEP;
      end
    end
  end

  ifetch_fifo u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push       (push),
    .push_data  (push_data),
    .pop        (transfer),
    .flush      (jump),
    .count      (fifo_count),
    .head_valid (if_valid),
    .head       (head)
  );

  assign if_instr = head.instr;
  assign if_pc    = head.pc;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, byte address of the first fetch after reset; bits [1:0] are ignored.
REQ-002 Port: clock  input  1  single clock, all state on rising edge.
REQ-003 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port: instr_address  output  [15:2]  word address to the instruction memory port.
REQ-005 Port: instr_data  input  32  memory read data, valid the cycle after its address was presented.
REQ-006 Port: jump  input  1  redirect request from execute.
REQ-007 Port: jump_target  input  16  redirect byte address; bits [1:0] are ignored.
REQ-008 Port: if_valid  output  1  fetched instruction available to decode.
REQ-009 Port: if_ready  input  1  decode accepts; a transfer occurs when if_valid and if_ready are both high.
REQ-010 Port: if_instr  output  32  instruction word.
REQ-011 Port: if_pc  output  16  byte address of if_instr, with [1:0] = 0.

Function
REQ-012 fetch_pc (16 bit) shall drive instr_address = fetch_pc[15:2] every cycle; the memory read has a fixed 1-cycle latency and no stall.
REQ-013 An issue shall occur on a cycle when occupancy (FIFO count + in-flight) < 2, or when it equals 2 and a transfer occurs that cycle.
REQ-014 On issue: set in-flight, record pc_inflight = fetch_pc, and advance fetch_pc by 4 modulo 2^16, so 16'hFFFC wraps to 16'h0000.
REQ-015 Without issue, fetch_pc shall hold.
REQ-016 In-flight data shall be written to the FIFO on the next rising edge as {pc_inflight, instr_data}.
REQ-017 The 2-entry output FIFO shall drive if_valid/if_instr/if_pc from its head; if_valid = (count != 0).
REQ-018 if_valid, if_instr and if_pc shall be registered, with no combinational path from instr_data.
REQ-019 While if_valid is high and if_ready is low, if_instr and if_pc shall hold stable.
REQ-020 Pipeline latency: an address issued before edge N produces if_valid at cycle N+2, at a sustained 1 instruction/cycle while if_ready stays high.
REQ-021 FIFO full (count 2) with if_ready low: no issue, no data loss, and the in-flight count shall never exceed free space.
REQ-022 Simultaneous FIFO write and pop: count shall remain unchanged.
REQ-023 On jump sampled high at an edge: fetch_pc <= {jump_target[15:2], 2'b00}, the FIFO shall be emptied, and the in-flight response shall be discarded (not written).
REQ-024 If jump and a transfer coincide, the transfer shall complete (head consumed) and everything else shall still be flushed.
REQ-025 jump shall take priority over issue in the same cycle; the target address shall appear on instr_address at cycle k+1, and its instruction at if_valid at cycle k+3.
REQ-026 Back-to-back jumps on consecutive cycles: the last jump wins, and no instruction from an earlier target shall appear.

Reset
REQ-027 While resetn is low: fetch_pc = RESET_PC & 16'hFFFC, in-flight = 0, FIFO count = 0, if_valid = 0, if_instr = 0, if_pc = 0.
REQ-028 First issue shall occur in the first cycle after resetn deasserts; first if_valid shall be at the 3rd cycle.
REQ-029 Reset asserted mid-operation shall immediately clear if_valid and discard in-flight and buffered data.

Structure
REQ-030 RESET_PC default, instruction width (32) and PC width (16) shall live in shared package falcon_pkg.
REQ-031 The 2-entry FIFO (push, pop, flush, count, head outputs) shall be a sub-module named ifetch_fifo.
REQ-032 Occupancy/issue logic and fetch_pc shall remain in instruction_fetch.

Verification
REQ-033 Reset release, if_ready=1, memory model returning word = address: if_pc 0,4,8,... with if_instr 0,1,2,... from cycle 3, one per cycle.
REQ-034 if_ready=0 for 5 cycles after first valid: if_pc stays 0, exactly 2 entries buffered, and on release 0,4,8 are delivered with no gap or duplicate.
REQ-035 jump=1, jump_target=16'h0103 while 2 entries buffered: the next valid is if_pc=16'h0100 at cycle k+3, and no stale pc appears.
REQ-036 jump coinciding with a transfer at if_pc=8: pc 8 is consumed once, and the next pc is the target.
REQ-037 fetch_pc started at 16'hFFF8 via jump: sequence FFF8, FFFC, 0000, 0004.
REQ-038 resetn pulsed low while full and stalled: if_valid=0 immediately, and the restart delivers RESET_PC after 3 cycles.
